// File: rtl/id_stage_hazard.sv
// id_stage_hazard
//   Decode stage of the MIPS pipeline, sitting between the IF/ID register
//   and EX. Holds the register file (with a write-back-to-decode bypass),
//   the main control decoder, the load-use hazard detector that stalls IF,
//   the EX-driven flush, and the ID/EX pipeline register with a valid bit.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   if_valid/if_instr/if_pc_next   instruction, validity and PC+4 from IF/ID
//   wb_we/wb_addr/wb_data          register-file write port from write-back
//   ex_flush            taken branch in EX; the instruction in ID is killed
//   stall               combinational hold request for PC and IF/ID
//   id_ex_valid         ID/EX holds a live instruction
//   read_data1/2, extended_bits, instr_bits_*, new_pc_value
//                       registered operands, immediate, fields and PC+4
//   RegDst..Branch, load_mode, ALUOp   registered control outputs
module id_stage_hazard #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 2 ** REG_ADDR_W,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_valid,
    input  logic [31:0]           if_instr,
    input  logic [31:0]           if_pc_next,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  ex_flush,
    output logic                  stall,
    output logic                  id_ex_valid,
    output logic [DATA_W-1:0]     read_data1,
    output logic [DATA_W-1:0]     read_data2,
    output logic [DATA_W-1:0]     extended_bits,
    output logic [4:0]            instr_bits_25_21,
    output logic [4:0]            instr_bits_20_16,
    output logic [4:0]            instr_bits_15_11,
    output logic [31:0]           new_pc_value,
    output logic                  RegDst,
    output logic                  RegWrite,
    output logic                  ALUSrc,
    output logic                  MemWrite,
    output logic                  MemRead,
    output logic                  MemToReg,
    output logic                  Branch,
    output logic [1:0]            load_mode,
    output logic [2:0]            ALUOp
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    logic [DATA_W-1:0]     regs [NUM_REGS];
    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rs_idx;
    logic [REG_ADDR_W-1:0] rt_idx;
    logic [REG_ADDR_W-1:0] ex_rt_idx;
    logic [DATA_W-1:0]     rd1_c;
    logic [DATA_W-1:0]     rd2_c;
    logic [DATA_W-1:0]     imm_ext;
    logic                  wb_write_ok;

    logic       dec_reg_dst;
    logic       dec_reg_write;
    logic       dec_alu_src;
    logic       dec_mem_write;
    logic       dec_mem_read;
    logic       dec_mem_to_reg;
    logic       dec_branch;
    logic [1:0] dec_load_mode;
    logic [2:0] dec_alu_op;
    logic       dec_zext;
    logic       dec_uses_rs;
    logic       dec_uses_rt;

    logic       load_ctrl;

    assign opcode    = if_instr[31:26];
    assign rs_idx    = if_instr[21 +: REG_ADDR_W];
    assign rt_idx    = if_instr[16 +: REG_ADDR_W];
    assign ex_rt_idx = instr_bits_20_16[REG_ADDR_W-1:0];

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    assign wb_write_ok = wb_we
                         && !(ZERO_REG && (wb_addr == '0))
                         && (int'(wb_addr) < NUM_REGS);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write_ok) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Bypass lets an instruction in ID see the value being written back
    // in the same cycle, so WB and ID need no extra forwarding stage.
    always_comb begin
        rd1_c = '0;
        if (ZERO_REG && (rs_idx == '0)) begin
            rd1_c = '0;
        end else if (wb_we && (wb_addr == rs_idx)) begin
            rd1_c = wb_data;
        end else if (int'(rs_idx) < NUM_REGS) begin
            rd1_c = regs[rs_idx];
        end
    end

    always_comb begin
        rd2_c = '0;
        if (ZERO_REG && (rt_idx == '0)) begin
            rd2_c = '0;
        end else if (wb_we && (wb_addr == rt_idx)) begin
            rd2_c = wb_data;
        end else if (int'(rt_idx) < NUM_REGS) begin
            rd2_c = regs[rt_idx];
        end
    end

    // ------------------------------------------------------------------
    // Main decoder
    // ------------------------------------------------------------------
    always_comb begin
        dec_reg_dst    = 1'b0;
        dec_reg_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_branch     = 1'b0;
        dec_load_mode  = 2'b00;
        dec_alu_op     = 3'b000;
        dec_zext       = 1'b0;
        dec_uses_rs    = 1'b1;
        dec_uses_rt    = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                dec_reg_dst   = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_op    = 3'b010;
                dec_uses_rt   = 1'b1;
            end
            OP_LW, OP_LH, OP_LB: begin
                dec_alu_src    = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_reg_write  = 1'b1;
                dec_load_mode  = (opcode == OP_LH) ? 2'b01 :
                                 (opcode == OP_LB) ? 2'b10 : 2'b00;
            end
            OP_SW: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                dec_uses_rt   = 1'b1;
            end
            OP_BEQ: begin
                dec_branch  = 1'b1;
                dec_alu_op  = 3'b001;
                dec_uses_rt = 1'b1;
            end
            OP_ADDI: begin
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_ANDI: begin
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_op    = 3'b011;
                dec_zext      = 1'b1;
            end
            OP_ORI: begin
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_op    = 3'b100;
                dec_zext      = 1'b1;
            end
            default: begin
                dec_uses_rs = 1'b0;
            end
        endcase
    end

    // Fill the upper bits first, then drop the raw 16-bit field on top;
    // this also works when DATA_W is exactly 16.
    always_comb begin
        imm_ext       = {DATA_W{if_instr[15] & ~dec_zext}};
        imm_ext[15:0] = if_instr[15:0];
    end

    // ------------------------------------------------------------------
    // Load-use hazard: the load in EX cannot forward in time, so hold IF
    // for one cycle; the bubble clears MemRead and releases the stall.
    // ------------------------------------------------------------------
    always_comb begin
        stall = 1'b0;
        if (!reset && if_valid && id_ex_valid && MemRead
            && !(ZERO_REG && (ex_rt_idx == '0))) begin
            if ((dec_uses_rs && (ex_rt_idx == rs_idx))
                || (dec_uses_rt && (ex_rt_idx == rt_idx))) begin
                stall = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    assign load_ctrl = if_valid && !ex_flush && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_valid      <= 1'b0;
            read_data1       <= '0;
            read_data2       <= '0;
            extended_bits    <= '0;
            instr_bits_25_21 <= '0;
            instr_bits_20_16 <= '0;
            instr_bits_15_11 <= '0;
            new_pc_value     <= '0;
            RegDst           <= 1'b0;
            RegWrite         <= 1'b0;
            ALUSrc           <= 1'b0;
            MemWrite         <= 1'b0;
            MemRead          <= 1'b0;
            MemToReg         <= 1'b0;
            Branch           <= 1'b0;
            load_mode        <= 2'b00;
            ALUOp            <= 3'b000;
        end else begin
            // Datapath fields are don't-care in a bubble; only the valid
            // bit and the controls need to be squashed.
            read_data1       <= rd1_c;
            read_data2       <= rd2_c;
            extended_bits    <= imm_ext;
            instr_bits_25_21 <= if_instr[25:21];
            instr_bits_20_16 <= if_instr[20:16];
            instr_bits_15_11 <= if_instr[15:11];
            new_pc_value     <= if_pc_next;
            id_ex_valid      <= load_ctrl;
            RegDst           <= load_ctrl & dec_reg_dst;
            RegWrite         <= load_ctrl & dec_reg_write;
            ALUSrc           <= load_ctrl & dec_alu_src;
            MemWrite         <= load_ctrl & dec_mem_write;
            MemRead          <= load_ctrl & dec_mem_read;
            MemToReg         <= load_ctrl & dec_mem_to_reg;
            Branch           <= load_ctrl & dec_branch;
            load_mode        <= load_ctrl ? dec_load_mode : 2'b00;
            ALUOp            <= load_ctrl ? dec_alu_op : 3'b000;
        end
    end

endmodule

// File: tb/tb_id_stage_hazard.sv
// tb_id_stage_hazard
//   Directed, table-driven bench for id_stage_hazard plus hand-written
//   multi-cycle sequences (load-use, flush, reset priority) and a second
//   instance with DATA_W = 64, REG_ADDR_W = 3.
module tb_id_stage_hazard;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_LH   = 6'b100001;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    // {RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch}
    localparam logic [6:0] C_R   = 7'b1100000;
    localparam logic [6:0] C_LD  = 7'b0110110;
    localparam logic [6:0] C_SW  = 7'b0011000;
    localparam logic [6:0] C_BEQ = 7'b0000001;
    localparam logic [6:0] C_IMM = 7'b0110000;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc_next;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_flush;
    logic        stall;
    logic        id_ex_valid;
    logic [31:0] read_data1, read_data2, extended_bits;
    logic [4:0]  instr_bits_25_21, instr_bits_20_16, instr_bits_15_11;
    logic [31:0] new_pc_value;
    logic        RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch;
    logic [1:0]  load_mode;
    logic [2:0]  ALUOp;
    logic [6:0]  a_ctrl;

    logic        b_reset;
    logic        b_if_valid;
    logic [31:0] b_if_instr;
    logic        b_wb_we;
    logic [2:0]  b_wb_addr;
    logic [63:0] b_wb_data;
    logic        b_stall, b_id_ex_valid;
    logic [63:0] b_read_data1, b_read_data2, b_extended_bits;
    logic [4:0]  b_f1, b_f2, b_f3;
    logic [31:0] b_pc;
    logic        b_reg_dst, b_reg_write, b_alu_src, b_mem_write, b_mem_read;
    logic        b_mem_to_reg, b_branch;
    logic [1:0]  b_load_mode;
    logic [2:0]  b_alu_op;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign a_ctrl = {RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch};

    id_stage_hazard dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc_next(if_pc_next), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .ex_flush(ex_flush), .stall(stall),
        .id_ex_valid(id_ex_valid), .read_data1(read_data1),
        .read_data2(read_data2), .extended_bits(extended_bits),
        .instr_bits_25_21(instr_bits_25_21), .instr_bits_20_16(instr_bits_20_16),
        .instr_bits_15_11(instr_bits_15_11), .new_pc_value(new_pc_value),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemToReg(MemToReg),
        .Branch(Branch), .load_mode(load_mode), .ALUOp(ALUOp)
    );

    id_stage_hazard #(.DATA_W(64), .REG_ADDR_W(3)) dut_b (
        .clk(clk), .reset(b_reset), .if_valid(b_if_valid), .if_instr(b_if_instr),
        .if_pc_next(32'h0000_0100), .wb_we(b_wb_we), .wb_addr(b_wb_addr),
        .wb_data(b_wb_data), .ex_flush(1'b0), .stall(b_stall),
        .id_ex_valid(b_id_ex_valid), .read_data1(b_read_data1),
        .read_data2(b_read_data2), .extended_bits(b_extended_bits),
        .instr_bits_25_21(b_f1), .instr_bits_20_16(b_f2),
        .instr_bits_15_11(b_f3), .new_pc_value(b_pc),
        .RegDst(b_reg_dst), .RegWrite(b_reg_write), .ALUSrc(b_alu_src),
        .MemWrite(b_mem_write), .MemRead(b_mem_read), .MemToReg(b_mem_to_reg),
        .Branch(b_branch), .load_mode(b_load_mode), .ALUOp(b_alu_op)
    );

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        fl;
        logic        e_stall;
        logic        e_valid;
        logic        chk_data;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_ext;
        logic [6:0]  e_ctrl;
        logic [1:0]  e_lm;
        logic [2:0]  e_alu;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic fl);
        if_valid = v;
        if_instr = instr;
        ex_flush = fl;
    endtask

    initial begin
        reset = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc_next = '0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0; ex_flush = 1'b0;
        b_reset = 1'b1; b_if_valid = 1'b0; b_if_instr = '0;
        b_wb_we = 1'b0; b_wb_addr = '0; b_wb_data = '0;

        vecs[0]  = '{1'b1, r_type(5'd3, 5'd3, 5'd1), 32'h1004, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0,
                     1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0000_0820, C_R, 2'b00, 3'b010};
        vecs[1]  = '{1'b1, i_type(OP_ADDI, 5'd3, 5'd6, 16'hFFF0), 32'h1008, 1'b1, 5'd7, 32'h12345678, 1'b0,
                     1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h0, 32'hFFFF_FFF0, C_IMM, 2'b00, 3'b000};
        vecs[2]  = '{1'b1, i_type(OP_ORI, 5'd7, 5'd6, 16'hFFF0), 32'h100C, 1'b0, 5'd0, 32'h0, 1'b0,
                     1'b0, 1'b1, 1'b1, 32'h12345678, 32'h0, 32'h0000_FFF0, C_IMM, 2'b00, 3'b100};
        vecs[3]  = '{1'b1, i_type(OP_ANDI, 5'd3, 5'd6, 16'h8001), 32'h1010, 1'b0, 5'd0, 32'h0, 1'b0,
                     1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0000_8001, C_IMM, 2'b00, 3'b011};
        vecs[4]  = '{1'b1, i_type(OP_LB, 5'd0, 5'd8, 16'h0004), 32'h1014, 1'b0, 5'd0, 32'h0, 1'b0,
                     1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0000_0004, C_LD, 2'b10, 3'b000};
        vecs[5]  = '{1'b1, i_type(OP_SW, 5'd3, 5'd7, 16'h0008), 32'h1018, 1'b0, 5'd0, 32'h0, 1'b0,
                     1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 32'h0000_0008, C_SW, 2'b00, 3'b000};
        vecs[6]  = '{1'b1, i_type(OP_LH, 5'd7, 5'd9, 16'hFFFC), 32'h101C, 1'b0, 5'd0, 32'h0, 1'b0,
                     1'b0, 1'b1, 1'b1, 32'h12345678, 32'h0, 32'hFFFF_FFFC, C_LD, 2'b01, 3'b000};
        vecs[7]  = '{1'b1, i_type(OP_BEQ, 5'd3, 5'd7, 16'h0010), 32'h1020, 1'b0, 5'd0, 32'h0, 1'b0,
                     1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 32'h0000_0010, C_BEQ, 2'b00, 3'b001};
        vecs[8]  = '{1'b1, i_type(6'b111111, 5'd3, 5'd7, 16'h1234), 32'h1024, 1'b0, 5'd0, 32'h0, 1'b0,
                     1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 32'h0000_1234, 7'd0, 2'b00, 3'b000};
        vecs[9]  = '{1'b0, r_type(5'd3, 5'd7, 5'd1), 32'h1028, 1'b0, 5'd0, 32'h0, 1'b0,
                     1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 7'd0, 2'b00, 3'b000};
        vecs[10] = '{1'b1, r_type(5'd3, 5'd7, 5'd1), 32'h102C, 1'b0, 5'd0, 32'h0, 1'b1,
                     1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 7'd0, 2'b00, 3'b000};

        tick; tick;

        // ---- reset clears file and pipeline register ----
        reset = 1'b0; b_reset = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_0055;
        tick;
        wb_we = 1'b0;
        if_pc_next = 32'h0000_2000;
        drive(1'b1, i_type(OP_LW, 5'd5, 5'd6, 16'h0040), 1'b0);
        tick;
        chk("pre_reset_rd1", read_data1, 32'h55);
        reset = 1'b1;
        #1;
        chk("reset_stall", stall, 0);
        tick;
        chk("reset_valid", id_ex_valid, 0);
        chk("reset_ctrl", a_ctrl, 0);
        chk("reset_lm", load_mode, 0);
        chk("reset_alu", ALUOp, 0);
        chk("reset_rd1", read_data1, 0);
        chk("reset_ext", extended_bits, 0);
        chk("reset_pc", new_pc_value, 0);
        chk("reset_rs_field", instr_bits_25_21, 0);
        reset = 1'b0;
        drive(1'b1, r_type(5'd5, 5'd5, 5'd1), 1'b0);
        tick;
        chk("reset_r5_read", read_data1, 0);
        chk("reset_r5_valid", id_ex_valid, 1);

        // ---- table-driven single-cycle vectors ----
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].v, vecs[i].instr, vecs[i].fl);
            if_pc_next = vecs[i].pc;
            wb_we = vecs[i].we; wb_addr = vecs[i].wa; wb_data = vecs[i].wd;
            #1;
            chk($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
            tick;
            chk($sformatf("v%0d_valid", i), id_ex_valid, vecs[i].e_valid);
            chk($sformatf("v%0d_ctrl", i), a_ctrl, vecs[i].e_ctrl);
            chk($sformatf("v%0d_lm", i), load_mode, vecs[i].e_lm);
            chk($sformatf("v%0d_alu", i), ALUOp, vecs[i].e_alu);
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d_rd1", i), read_data1, vecs[i].e_rd1);
                chk($sformatf("v%0d_rd2", i), read_data2, vecs[i].e_rd2);
                chk($sformatf("v%0d_ext", i), extended_bits, vecs[i].e_ext);
                chk($sformatf("v%0d_pc", i), new_pc_value, vecs[i].pc);
                chk($sformatf("v%0d_rs", i), instr_bits_25_21, vecs[i].instr[25:21]);
                chk($sformatf("v%0d_rt", i), instr_bits_20_16, vecs[i].instr[20:16]);
                chk($sformatf("v%0d_rd", i), instr_bits_15_11, vecs[i].instr[15:11]);
            end
        end
        wb_we = 1'b0; ex_flush = 1'b0;

        // ---- load-use on rs: one stall, one bubble, then the add ----
        drive(1'b1, i_type(OP_LW, 5'd0, 5'd2, 16'h0004), 1'b0);
        #1;
        chk("lu_lw_stall", stall, 0);
        tick;
        chk("lu_lw_memread", MemRead, 1);
        drive(1'b1, r_type(5'd2, 5'd1, 5'd4), 1'b0);
        #1;
        chk("lu_stall", stall, 1);
        tick;
        chk("lu_bubble_valid", id_ex_valid, 0);
        chk("lu_bubble_ctrl", a_ctrl, 0);
        chk("lu_stall_released", stall, 0);
        tick;
        chk("lu_add_valid", id_ex_valid, 1);
        chk("lu_add_ctrl", a_ctrl, C_R);
        chk("lu_add_rd", instr_bits_15_11, 5'd4);

        // ---- rt only as destination: no stall; rt as source: stall ----
        drive(1'b1, i_type(OP_LW, 5'd0, 5'd2, 16'h0004), 1'b0);
        tick;
        drive(1'b1, i_type(OP_ADDI, 5'd1, 5'd2, 16'h0001), 1'b0);
        #1;
        chk("lu_addi_rt_dest", stall, 0);
        drive(1'b1, i_type(OP_SW, 5'd1, 5'd2, 16'h0000), 1'b0);
        #1;
        chk("lu_sw_rt_src", stall, 1);
        tick;
        chk("lu_sw_bubble", id_ex_valid, 0);

        // ---- load to r0 never stalls ----
        drive(1'b1, i_type(OP_LW, 5'd0, 5'd0, 16'h0004), 1'b0);
        tick;
        drive(1'b1, r_type(5'd0, 5'd1, 5'd4), 1'b0);
        #1;
        chk("lu_r0_stall", stall, 0);
        tick;
        chk("lu_r0_valid", id_ex_valid, 1);

        // ---- flush wins over a concurrent stall ----
        drive(1'b1, i_type(OP_LW, 5'd0, 5'd2, 16'h0004), 1'b0);
        tick;
        drive(1'b1, i_type(OP_BEQ, 5'd2, 5'd1, 16'h0003), 1'b1);
        tick;
        chk("fl_valid", id_ex_valid, 0);
        chk("fl_branch", Branch, 0);
        chk("fl_regwrite", RegWrite, 0);
        ex_flush = 1'b0;
        #1;
        chk("fl_after_stall", stall, 0);
        tick;
        chk("fl_after_branch", Branch, 1);

        // ---- flush kills a store ----
        drive(1'b1, i_type(OP_SW, 5'd3, 5'd7, 16'h0008), 1'b1);
        tick;
        chk("fl_sw_memwrite", MemWrite, 0);
        chk("fl_sw_valid", id_ex_valid, 0);
        ex_flush = 1'b0;

        // ---- reset overrides a pending stall ----
        drive(1'b1, i_type(OP_LW, 5'd0, 5'd2, 16'h0004), 1'b0);
        tick;
        drive(1'b1, r_type(5'd2, 5'd1, 5'd4), 1'b0);
        #1;
        chk("rst_pre_stall", stall, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_stall", stall, 0);
        tick;
        chk("rst_mid_valid", id_ex_valid, 0);
        chk("rst_mid_memread", MemRead, 0);
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0);

        // ---- 64-bit / 3-bit-address instance: r9 aliases r1 ----
        b_wb_we = 1'b1; b_wb_addr = 3'd1; b_wb_data = 64'hA5A5_0000_1111_2222;
        tick;
        b_wb_we = 1'b0;
        b_if_valid = 1'b1;
        b_if_instr = i_type(OP_ADDI, 5'd9, 5'd1, 16'h8000);
        tick;
        chk("p64_rs9_alias", b_read_data1, 64'hA5A5_0000_1111_2222);
        chk("p64_rt1", b_read_data2, 64'hA5A5_0000_1111_2222);
        chk("p64_sext", b_extended_bits, 64'hFFFF_FFFF_FFFF_8000);
        chk("p64_rs_field", b_f1, 5'd9);
        chk("p64_valid", b_id_ex_valid, 1);
        b_if_instr = i_type(OP_ORI, 5'd2, 5'd3, 16'h8000);
        tick;
        chk("p64_zext", b_extended_bits, 64'h0000_0000_0000_8000);
        chk("p64_unwritten", b_read_data1, 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
